// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite subordinate with a word-addressed register memory,
// programmable wait states and a two-cycle ERROR response.
module ahb_slave_mem #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);
    localparam int IDXW = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  WS   = 4'(WAIT_STATES);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic                write_q, write_d;
    logic                hready_q, hready_d;
    logic                hresp_q, hresp_d;
    logic [31:0]         mem_q [DEPTH];

    logic [32:0]         offset;
    logic                addr_err;
    logic                accept;
    logic                wr_en;
    logic                unused_htrans;

    assign unused_htrans = HTRANS[0];

    // Offset is taken in 33 bits so an address below the base cannot wrap into range.
    assign offset   = {1'b0, HADDR} - {1'b0, ADDR_BASE};
    assign addr_err = (HADDR[1:0] != 2'b00) || (HADDR < ADDR_BASE) || (offset >= SPAN);
    assign accept   = HSEL && HTRANS[1] && hready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[idx_q] <= HWDATA;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        if (accept) begin
            idx_d   = offset[IDXW+1:2];
            write_d = HWRITE;
        end
        case (state_q)
            S_WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? S_LAST : S_WAIT;
            end
            S_ERR1:  state_d = S_ERR2;
            default: begin
                if (!accept)             state_d = S_IDLE;
                else if (addr_err)       state_d = S_ERR1;
                else if (WS != 4'd0) begin
                    state_d = S_WAIT;
                    cnt_d   = WS;
                end else                 state_d = S_LAST;
            end
        endcase
    end

    // HREADY/HRESP are registered by decoding the next state.
    always_comb begin
        hready_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
        hresp_d  = (state_d == S_ERR1) || (state_d == S_ERR2);
        wr_en    = (state_q == S_LAST) && write_q;
        HRDATA   = ((state_q == S_LAST) && !write_q) ? mem_q[idx_q] : 32'h0;
    end

    assign HREADY = hready_q;
    assign HRESP  = hresp_q;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb/tb_ahb_slave_mem.sv - directed bench for ahb_slave_mem with 0, 3 and 2 wait states.
module tb_ahb_slave_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [31:0] rdata0, rdata1, rdata2;
    logic        rdy0, rdy1, rdy2;
    logic        resp0, resp1, resp2;
    int          sel;
    logic [31:0] cur_rdata;
    logic        cur_ready, cur_resp;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ahb_slave_mem #(.ADDR_BASE(32'h0), .DEPTH(16), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HWDATA(hwdata), .HRDATA(rdata0), .HREADY(rdy0), .HRESP(resp0));
    ahb_slave_mem #(.ADDR_BASE(32'h0), .DEPTH(16), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HWDATA(hwdata), .HRDATA(rdata1), .HREADY(rdy1), .HRESP(resp1));
    ahb_slave_mem #(.ADDR_BASE(32'h0), .DEPTH(16), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HWDATA(hwdata), .HRDATA(rdata2), .HREADY(rdy2), .HRESP(resp2));

    always_comb begin
        cur_rdata = rdata0;
        cur_ready = rdy0;
        cur_resp  = resp0;
        if (sel == 1) begin
            cur_rdata = rdata1; cur_ready = rdy1; cur_resp = resp1;
        end else if (sel == 2) begin
            cur_rdata = rdata2; cur_ready = rdy2; cur_resp = resp2;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0;
    endtask

    task automatic do_reset();
        bus_idle();
        hwdata = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Single non-pipelined transfer; reports low cycles, HRESP seen while low,
    // and HRDATA/HRESP in the completing cycle.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        output int waits, output logic low_resp,
                        output logic [31:0] rd, output logic fin_resp);
        waits = 0; low_resp = 1'b0;
        hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr;
        @(posedge clk);
        #1;
        bus_idle();
        hwdata = wd;
        @(negedge clk);
        while (!cur_ready && waits < 20) begin
            waits++;
            low_resp = low_resp | cur_resp;
            @(negedge clk);
        end
        rd = cur_rdata;
        fin_resp = cur_resp;
        @(posedge clk);
        #1 hwdata = 32'h0;
    endtask

    int          w;
    logic        lr, fr;
    logic [31:0] rd;

    initial begin
        sel = 0;
        rst = 1'b1;
        bus_idle();
        hwdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hready", 32'(cur_ready), 32'h1);
            check("reset_hresp", 32'(cur_resp), 32'h0);
            check("reset_hrdata", cur_rdata, 32'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        xfer(32'h8, 1'b0, 32'h0, w, lr, rd, fr);
        check("rd8_after_reset", rd, 32'h0);
        check("rd8_waits", 32'(w), 32'd0);

        xfer(32'h4, 1'b1, 32'hDEAD_BEEF, w, lr, rd, fr);
        check("ws0_write_waits", 32'(w), 32'd0);
        check("ws0_write_resp", 32'(fr), 32'h0);
        xfer(32'h4, 1'b0, 32'h0, w, lr, rd, fr);
        check("ws0_read_waits", 32'(w), 32'd0);
        check("ws0_read_data", rd, 32'hDEAD_BEEF);

        // Pipelined write then read of the same word, one transfer per cycle.
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1;
        @(posedge clk);
        #1 hwrite = 1'b0; hwdata = 32'hA5A5_A5A5;
        @(negedge clk);
        check("pipe_wr_ready", 32'(cur_ready), 32'h1);
        @(posedge clk);
        #1 bus_idle(); hwdata = 32'h0;
        @(negedge clk);
        check("pipe_rd_ready", 32'(cur_ready), 32'h1);
        check("pipe_rd_data", cur_rdata, 32'hA5A5_A5A5);
        check("pipe_rd_resp", 32'(cur_resp), 32'h0);
        @(posedge clk);
        #1;

        xfer(32'h40, 1'b0, 32'h0, w, lr, rd, fr);
        check("err_oob_low", 32'(w), 32'd1);
        check("err_oob_resp1", 32'(lr), 32'h1);
        check("err_oob_resp2", 32'(fr), 32'h1);
        check("err_oob_rdata", rd, 32'h0);
        xfer(32'h2, 1'b1, 32'h0000_0BAD, w, lr, rd, fr);
        check("err_unal_low", 32'(w), 32'd1);
        check("err_unal_resp1", 32'(lr), 32'h1);
        check("err_unal_resp2", 32'(fr), 32'h1);
        xfer(32'h0, 1'b0, 32'h0, w, lr, rd, fr);
        check("post_err_resp", 32'(fr), 32'h0);
        check("post_err_mem0", rd, 32'h0);
        xfer(32'h4, 1'b0, 32'h0, w, lr, rd, fr);
        check("post_err_mem4", rd, 32'hDEAD_BEEF);

        sel = 1;
        do_reset();
        xfer(32'hC, 1'b1, 32'h1234_5678, w, lr, rd, fr);
        check("ws3_write_waits", 32'(w), 32'd3);
        xfer(32'hC, 1'b0, 32'h0, w, lr, rd, fr);
        check("ws3_read_waits", 32'(w), 32'd3);
        check("ws3_read_low_resp", 32'(lr), 32'h0);
        check("ws3_read_data", rd, 32'h1234_5678);
        check("ws3_read_resp", 32'(fr), 32'h0);

        sel = 2;
        do_reset();
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0; hwrite = 1'b1;
        @(posedge clk);
        #1 bus_idle(); hwdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("ws2_in_wait", 32'(cur_ready), 32'h0);
        rst = 1'b1;
        #1;
        check("async_rst_hready", 32'(cur_ready), 32'h1);
        check("async_rst_hresp", 32'(cur_resp), 32'h0);
        check("async_rst_hrdata", cur_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        hwdata = 32'h0;
        xfer(32'h0, 1'b0, 32'h0, w, lr, rd, fr);
        check("ws2_read_waits", 32'(w), 32'd2);
        check("ws2_read_after_rst", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- AHB-Lite style subordinate (responder) for the bus driven by our AHB master.
- Holds a word-addressed register memory of DEPTH 32-bit words at ADDR_BASE.
- Implements pipelined address/data phases, programmable wait states, and a two-cycle ERROR response.
- Single-subordinate system: its HREADY output is the bus HREADY seen by the master.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte base address of the memory window.
- DEPTH, 16, number of 32-bit words; power of two, 2..256.
- WAIT_STATES, 0, HREADY-low cycles inserted per OKAY data phase; 0..15.

Ports:
- clk  in  1  bus clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- HSEL  in  1  subordinate select.
- HADDR  in  32  byte address, address phase.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write, 0 = read, address phase.
- HWDATA  in  32  write data, data phase.
- HRDATA  out  32  read data, data phase.
- HREADY  out  1  registered; 1 = current data phase completes this cycle.
- HRESP  out  1  registered; 0 OKAY, 1 ERROR.

Behaviour:
- Reset (asynchronous assert, any state):
  - HREADY=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0, all memory words 0.
  - An in-flight write is discarded; no partial update.
- Accept: a transfer is accepted at an edge where HSEL=1, HTRANS[1]=1 and HREADY=1.
  - At that edge latch the index (HADDR-ADDR_BASE)>>2, HWRITE and an error flag.
- Error flag is set when:
  - HADDR[1:0]!=0, or
  - HADDR<ADDR_BASE, or
  - HADDR-ADDR_BASE >= DEPTH*4 (compute in 33 bits; no wrap).
- IDLE, BUSY, or HSEL=0 with HREADY=1: no access, no state change; HREADY stays 1, HRESP 0.
- States: IDLE, WAIT, LAST, ERR1, ERR2.
- IDLE:
  - Accept with error goes to ERR1.
  - Accept with WAIT_STATES>0 goes to WAIT, counter loaded with WAIT_STATES.
  - Accept with WAIT_STATES=0 goes to LAST.
- WAIT:
  - HREADY=0, HRESP=0; counter decrements each cycle.
  - Goes to LAST the cycle after the counter reaches 1.
  - Exactly WAIT_STATES low cycles.
- LAST (final data-phase cycle):
  - HREADY=1, HRESP=0.
  - Write: mem[idx] <= HWDATA at the edge ending LAST.
  - Read: HRDATA = mem[idx] throughout LAST; HRDATA=0 outside read LAST cycles.
  - A new accept at the LAST-ending edge overlaps (pipelined); next state follows the IDLE rules, otherwise IDLE.
- ERR1: HREADY=0, HRESP=1; always goes to ERR2. No memory access.
- ERR2:
  - HREADY=1, HRESP=1; goes to IDLE or accepts a new transfer per the IDLE rules.
  - HRDATA=0.
- Latency: accept to completion edge is WAIT_STATES+1 cycles for OKAY, 2 cycles for ERROR.
- Hazard: a read accepted at the same edge that completes a write to the same index returns the new HWDATA; no stale data.
- HWDATA is ignored in WAIT cycles; only the value at the LAST-ending edge is written.
- Back-to-back zero-wait transfers sustain one transfer per cycle.

Test Plan:
- Reset, then observe 3 cycles → HREADY=1, HRESP=0, HRDATA=0; read 0x8 returns 0.
- WAIT_STATES=0: write 0x4 = 32'hDEADBEEF, then read 0x4 → HREADY never low; HRDATA=32'hDEADBEEF in the read data cycle.
- WAIT_STATES=3: read 0xC after writing 32'h1234_5678 → exactly 3 HREADY-low cycles, then HREADY=1 with HRDATA=32'h1234_5678.
- Pipelined write 0x10 = 32'hA5A5A5A5 immediately followed by read 0x10 → read returns 32'hA5A5A5A5, one transfer per cycle.
- Errors: read 0x40 with DEPTH=16, and write 0x2 (unaligned) → each gives HREADY=0/HRESP=1, then HREADY=1/HRESP=1; memory unchanged; next valid transfer is OKAY.
- WAIT_STATES=2: assert rst during WAIT of a write 0x0 = 32'hFFFF_FFFF, then release → outputs at reset values immediately; read 0x0 returns 0.
